// File: rtl/bas_run_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bas_run_sequencer                                          |
// | Description : Multi-restart controller for the Beetle Antennae Search    |
// |               core. Resets, loads and supervises the core once per run,  |
// |               keeps the global best (lowest signed value) and offers it  |
// |               on a valid/ready result port.                              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clock, reset            : clock, synchronous active-high reset         |
// |   start                   : one-cycle sequence request (IDLE only)       |
// |   num_runs                : restarts per sequence, 0 = ignore start      |
// |   iterations              : iterations per run, forwarded to the core    |
// |   base_seed_x/y           : seeds of run 0                               |
// |   start_x/y               : Q8.8 start position, same for every run      |
// |   busy                    : high in every state except IDLE              |
// |   core_reset/core_load    : core control strobes                         |
// |   core_seed_x/y           : seeds of the current run (never zero)        |
// |   core_iterations         : latched iteration count                      |
// |   core_x/y                : latched start position                       |
// |   core_x/y_extreme        : core best position                           |
// |   core_out_value          : core best value (signed)                     |
// |   core_done               : core finished the current run                |
// |   res_valid/res_ready     : result handshake                             |
// |   res_x/y, res_value      : global best position and value               |
// |   res_best_run            : index of the winning run                     |
// |   res_timeouts            : runs aborted by the watchdog                 |
// +--------------------------------------------------------------------------+
module bas_run_sequencer #(
  parameter int         RUN_W         = 4,
  parameter logic [8:0] SEED_STEP_X   = 9'd37,
  parameter logic [8:0] SEED_STEP_Y   = 9'd101,
  parameter int         TIMEOUT_SLACK = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [RUN_W-1:0] num_runs,
  input  logic [8:0]       iterations,
  input  logic [8:0]       base_seed_x,
  input  logic [8:0]       base_seed_y,
  input  logic [15:0]      start_x,
  input  logic [15:0]      start_y,
  output logic             busy,
  output logic             core_reset,
  output logic             core_load,
  output logic [8:0]       core_seed_x,
  output logic [8:0]       core_seed_y,
  output logic [8:0]       core_iterations,
  output logic [15:0]      core_x,
  output logic [15:0]      core_y,
  input  logic [15:0]      core_x_extreme,
  input  logic [15:0]      core_y_extreme,
  input  logic [39:0]      core_out_value,
  input  logic             core_done,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_x,
  output logic [15:0]      res_y,
  output logic [39:0]      res_value,
  output logic [RUN_W-1:0] res_best_run,
  output logic [RUN_W-1:0] res_timeouts
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CORE_RST  = 3'd1,
    ST_CORE_LOAD = 3'd2,
    ST_RUN       = 3'd3,
    ST_COMPARE   = 3'd4,
    ST_NEXT      = 3'd5,
    ST_OUTPUT    = 3'd6
  } state_t;

  localparam logic [39:0]      VALUE_MAX = 40'h7F_FFFF_FFFF;
  localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);
  localparam logic [9:0]       SLACK_10  = 10'(TIMEOUT_SLACK);

  state_t           state;
  state_t           state_next;

  logic [RUN_W-1:0] num_runs_q;
  logic [RUN_W-1:0] run_idx;
  logic [8:0]       raw_seed_x;
  logic [8:0]       raw_seed_y;
  logic [8:0]       raw_seed_x_step;
  logic [8:0]       raw_seed_y_step;
  logic [9:0]       watchdog;
  logic [9:0]       watchdog_inc;
  logic             watchdog_expired;
  logic             last_run;
  logic             accept_start;

  // An all-zero seed would lock the core LFSR, so zero is replaced by one.
  function automatic logic [8:0] fix_seed(input logic [8:0] s);
    return (s == 9'd0) ? 9'd1 : s;
  endfunction

  assign accept_start    = start && (num_runs != '0);
  assign raw_seed_x_step = raw_seed_x + SEED_STEP_X;
  assign raw_seed_y_step = raw_seed_y + SEED_STEP_Y;
  assign last_run        = (run_idx == (num_runs_q - RUN_ONE));

  // The watchdog counts RUN cycles including the current one; the run is
  // abandoned on the cycle that brings the count to iterations+slack.
  assign watchdog_inc     = watchdog + 10'd1;
  assign watchdog_expired = (watchdog_inc == ({1'b0, core_iterations} + SLACK_10));

  // ---------------------------------------------------------------- state
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ------------------------------------------------ next state and strobes
  always_comb begin
    state_next = state;
    busy       = 1'b1;
    core_reset = reset;
    core_load  = 1'b0;
    res_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (accept_start) begin
          state_next = ST_CORE_RST;
        end
      end
      ST_CORE_RST: begin
        core_reset = 1'b1;
        state_next = ST_CORE_LOAD;
      end
      ST_CORE_LOAD: begin
        core_load  = 1'b1;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        // A done arriving on the watchdog's last cycle still counts.
        if (core_done) begin
          state_next = ST_COMPARE;
        end else if (watchdog_expired) begin
          state_next = ST_NEXT;
        end
      end
      ST_COMPARE: begin
        state_next = ST_NEXT;
      end
      ST_NEXT: begin
        state_next = last_run ? ST_OUTPUT : ST_CORE_RST;
      end
      ST_OUTPUT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------- datapath
  always_ff @(posedge clock) begin
    if (reset) begin
      num_runs_q      <= '0;
      run_idx         <= '0;
      raw_seed_x      <= 9'd0;
      raw_seed_y      <= 9'd0;
      core_seed_x     <= 9'd1;
      core_seed_y     <= 9'd1;
      core_iterations <= 9'd0;
      core_x          <= 16'd0;
      core_y          <= 16'd0;
      watchdog        <= 10'd0;
      res_value       <= VALUE_MAX;
      res_x           <= 16'd0;
      res_y           <= 16'd0;
      res_best_run    <= '0;
      res_timeouts    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept_start) begin
            num_runs_q      <= num_runs;
            core_iterations <= iterations;
            core_x          <= start_x;
            core_y          <= start_y;
            raw_seed_x      <= base_seed_x;
            raw_seed_y      <= base_seed_y;
            core_seed_x     <= fix_seed(base_seed_x);
            core_seed_y     <= fix_seed(base_seed_y);
            run_idx         <= '0;
            res_value       <= VALUE_MAX;
            res_x           <= 16'd0;
            res_y           <= 16'd0;
            res_best_run    <= '0;
            res_timeouts    <= '0;
          end
        end
        ST_CORE_LOAD: begin
          watchdog <= 10'd0;
        end
        ST_RUN: begin
          watchdog <= watchdog_inc;
          if (!core_done && watchdog_expired) begin
            res_timeouts <= res_timeouts + RUN_ONE;
          end
        end
        ST_COMPARE: begin
          // Strict compare: on a tie the earlier run is kept.
          if ($signed(core_out_value) < $signed(res_value)) begin
            res_value    <= core_out_value;
            res_x        <= core_x_extreme;
            res_y        <= core_y_extreme;
            res_best_run <= run_idx;
          end
        end
        ST_NEXT: begin
          if (!last_run) begin
            run_idx     <= run_idx + RUN_ONE;
            raw_seed_x  <= raw_seed_x_step;
            raw_seed_y  <= raw_seed_y_step;
            core_seed_x <= fix_seed(raw_seed_x_step);
            core_seed_y <= fix_seed(raw_seed_y_step);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire
